// File: rtl/hex_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Holds the FSM encoding, the dark-digit pattern and the nibble-to-digit map.
package hex_display_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int NUM_DIGITS = 4;
  localparam int HEX0_LSB   = 0;
  localparam int HEX1_LSB   = 4;
  localparam int HEX2_LSB   = 8;
  localparam int HEX3_LSB   = 12;

  function automatic int digit_lsb(input int digit);
    case (digit)
      0:       digit_lsb = HEX0_LSB;
      1:       digit_lsb = HEX1_LSB;
      2:       digit_lsb = HEX2_LSB;
      3:       digit_lsb = HEX3_LSB;
      default: digit_lsb = HEX0_LSB;
    endcase
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment decoder; bit 0 is segment a, bit 6 is g.
module hex7seg (
  input  logic [3:0] hex,
  output logic [0:6] display
);

  // Segment lookup for each hex digit
  always_comb begin
    case (hex)
      4'h0:    display = 7'b0000001;
      4'h1:    display = 7'b1001111;
      4'h2:    display = 7'b0010010;
      4'h3:    display = 7'b0000110;
      4'h4:    display = 7'b1001100;
      4'h5:    display = 7'b0100100;
      4'h6:    display = 7'b0100000;
      4'h7:    display = 7'b0001111;
      4'h8:    display = 7'b0000000;
      4'h9:    display = 7'b0000100;
      4'hA:    display = 7'b0001000;
      4'hB:    display = 7'b1100000;
      4'hC:    display = 7'b0110001;
      4'hD:    display = 7'b1000010;
      4'hE:    display = 7'b0110000;
      4'hF:    display = 7'b0111000;
      default: display = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/hex_display_arbiter_rr_pick.sv
// Combinational round-robin winner search starting after `last`,
// optionally skipping one requester (the current owner).
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  input  logic             exclude_en,
  input  logic [IDX_W-1:0] exclude_idx,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand_s;

  // Walk last+1 .. last+NREQ and keep the first eligible requester
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    cand_s = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IDX_W'((int'(last) + k) % NREQ);
      if (!valid && req[cand_s] && !(exclude_en && (cand_s == exclude_idx))) begin
        valid = 1'b1;
        idx   = cand_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the four-digit seven-segment display with a minimum
// dwell time; the owner's value is registered and decoded onto HEX3..HEX0.
module hex_display_arbiter
  import hex_display_arbiter_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [16*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [15:0]       hex_value,
  output logic              blank,
  output logic [0:6]        HEX0,
  output logic [0:6]        HEX1,
  output logic [0:6]        HEX2,
  output logic [0:6]        HEX3
);

  localparam int IDX_W = (NREQ > 2) ? 2 : 1;

  state_e           state_r, state_s;
  logic [IDX_W-1:0] owner_r, owner_s;
  logic [IDX_W-1:0] last_r, last_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [NREQ-1:0]  gnt_r, gnt_s;
  logic [15:0]      hex_value_r, hex_value_s;
  logic             blank_r, blank_s;

  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             dwell_expired_s;
  logic [15:0]      data_words_s [NREQ];
  logic [0:6]       seg_raw_s [NUM_DIGITS];

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign data_words_s[g] = data[16*g +: 16];
  end

  // The owner is never a handover candidate, so release and preemption share one search
  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_pick (
    .req         (req),
    .last        (last_r),
    .exclude_en  (state_r == ST_OWN),
    .exclude_idx (owner_r),
    .valid       (pick_valid_s),
    .idx         (pick_idx_s)
  );

  assign dwell_expired_s = (cnt_r == CNT_W'(DWELL_CYCLES - 1));

  // Next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    last_s      = last_r;
    cnt_s       = cnt_r;
    gnt_s       = gnt_r;
    hex_value_s = hex_value_r;
    blank_s     = blank_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_s     = ST_OWN;
          owner_s     = pick_idx_s;
          last_s      = pick_idx_s;
          cnt_s       = '0;
          gnt_s       = onehot(pick_idx_s);
          hex_value_s = data_words_s[pick_idx_s];
          blank_s     = 1'b0;
        end else begin
          gnt_s   = '0;
          blank_s = 1'b1;
        end
      end
      ST_OWN: begin
        // Release wins over expiry; both hand over to the same excluded-owner pick
        if (pick_valid_s && (!req[owner_r] || dwell_expired_s)) begin
          owner_s     = pick_idx_s;
          last_s      = pick_idx_s;
          cnt_s       = '0;
          gnt_s       = onehot(pick_idx_s);
          hex_value_s = data_words_s[pick_idx_s];
          blank_s     = 1'b0;
        end else if (!req[owner_r]) begin
          state_s = ST_IDLE;
          gnt_s   = '0;
          blank_s = 1'b1;
        end else begin
          hex_value_s = data_words_s[owner_r];
          cnt_s       = dwell_expired_s ? cnt_r : (cnt_r + CNT_W'(1));
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = '0;
        blank_s = 1'b1;
        cnt_s   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      owner_r     <= IDX_W'(NREQ - 1);
      last_r      <= IDX_W'(NREQ - 1);
      cnt_r       <= '0;
      gnt_r       <= '0;
      hex_value_r <= 16'h0000;
      blank_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      last_r      <= last_s;
      cnt_r       <= cnt_s;
      gnt_r       <= gnt_s;
      hex_value_r <= hex_value_s;
      blank_r     <= blank_s;
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digits
    hex7seg u_hex7seg (
      .hex     (hex_value_r[digit_lsb(d) +: 4]),
      .display (seg_raw_s[d])
    );
  end

  assign gnt       = gnt_r;
  assign hex_value = hex_value_r;
  assign blank     = blank_r;
  assign HEX0      = blank_r ? SEG_BLANK : seg_raw_s[0];
  assign HEX1      = blank_r ? SEG_BLANK : seg_raw_s[1];
  assign HEX2      = blank_r ? SEG_BLANK : seg_raw_s[2];
  assign HEX3      = blank_r ? SEG_BLANK : seg_raw_s[3];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed self-checking bench for hex_display_arbiter with a short dwell.
module tb_hex_display_arbiter;

  localparam int NREQ  = 2;
  localparam int DWELL = 8;

  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_DARK = 7'b1111111;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NREQ-1:0]   req;
  logic [16*NREQ-1:0] data;
  logic [NREQ-1:0]   gnt;
  logic [15:0]       hex_value;
  logic              blank;
  logic [0:6]        HEX0, HEX1, HEX2, HEX3;

  int n_tests = 0;
  int n_fail  = 0;

  hex_display_arbiter #(.NREQ(NREQ), .DWELL_CYCLES(DWELL), .CNT_W(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .hex_value (hex_value),
    .blank     (blank),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, "_blank"}, 32'(blank), 32'd1);
    check_eq({tag, "_gnt"},   32'(gnt),   32'd0);
    check_eq({tag, "_hex0"},  32'(HEX0),  32'(SEG_DARK));
    check_eq({tag, "_hex3"},  32'(HEX3),  32'(SEG_DARK));
  endtask

  initial begin
    resetn = 1'b0;
    req    = 2'b00;
    data   = {16'hABCD, 16'h1234};
    step();
    step();
    check_dark("reset");
    check_eq("reset_value", 32'(hex_value), 32'h0000);
    resetn = 1'b1;
    step();
    check_dark("idle_no_req");

    // First grant: requester 0 with 1234
    req = 2'b01;
    step();
    check_eq("grant0_gnt",   32'(gnt),       32'h1);
    check_eq("grant0_value", 32'(hex_value), 32'h1234);
    check_eq("grant0_blank", 32'(blank),     32'd0);
    check_eq("grant0_hex0",  32'(HEX0),      32'(SEG_4));
    check_eq("grant0_hex1",  32'(HEX1),      32'(SEG_3));
    check_eq("grant0_hex2",  32'(HEX2),      32'(SEG_2));
    check_eq("grant0_hex3",  32'(HEX3),      32'(SEG_1));

    // Live tracking, then contention from requester 1 at cycle 2
    data[15:0] = 16'h5678;
    step();
    step();
    check_eq("track_value", 32'(hex_value), 32'h5678);
    req = 2'b11;
    for (int i = 3; i < DWELL; i++) begin
      step();
      check_eq("dwell_hold_gnt", 32'(gnt), 32'h1);
    end
    step();
    check_eq("preempt_gnt",   32'(gnt),       32'h2);
    check_eq("preempt_value", 32'(hex_value), 32'hABCD);

    // Owner 1 releases with nothing pending
    req = 2'b00;
    step();
    check_dark("release_idle");
    check_eq("release_held", 32'(hex_value), 32'hABCD);
    check_eq("release_hex1", 32'(HEX1), 32'(SEG_DARK));

    // Simultaneous requests after reset: 0 first, then 1 without a gap
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    req = 2'b11;
    step();
    check_eq("simul_gnt",   32'(gnt),       32'h1);
    check_eq("simul_value", 32'(hex_value), 32'h5678);
    req = 2'b10;
    step();
    check_eq("nogap_gnt",   32'(gnt),       32'h2);
    check_eq("nogap_blank", 32'(blank),     32'd0);
    check_eq("nogap_value", 32'(hex_value), 32'hABCD);

    // Dwell expires without a contender: owner retained
    data[31:16] = 16'h0F0F;
    for (int i = 0; i < DWELL + 4; i++) begin
      step();
      check_eq("retain_gnt", 32'(gnt), 32'h2);
    end
    check_eq("retain_value", 32'(hex_value), 32'h0F0F);
    req = 2'b11;
    step();
    check_eq("late_preempt_gnt",   32'(gnt),       32'h1);
    check_eq("late_preempt_value", 32'(hex_value), 32'h5678);

    // Requester 0 now holds its dwell against requester 1
    step();
    check_eq("new_dwell_gnt", 32'(gnt), 32'h1);

    // Asynchronous reset between edges
    #2;
    resetn = 1'b0;
    #1;
    check_dark("async_reset");
    check_eq("async_reset_value", 32'(hex_value), 32'h0000);
    #1;
    resetn = 1'b1;
    step();
    check_eq("restart_gnt",   32'(gnt),       32'h1);
    check_eq("restart_value", 32'(hex_value), 32'h5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shares the four-digit seven-segment display (HEX3..HEX0) between several 16-bit requesters, for example the embedded system's PIO export and on-board debug sources. Grants are round-robin with a minimum dwell time, so a busy requester cannot monopolise the display. The block latches the owner's value and drives the digits through hex7seg decoders. It sits between the Qsys system instance and the HEX pins at top level.

## Interface
- NREQ, 2: number of requesters, 2..4.
- DWELL_CYCLES, 50_000_000: minimum ownership time in clk cycles; 1 s at 50 MHz. Must be ≥2.
- CNT_W, 26: dwell counter width; must satisfy 2^CNT_W > DWELL_CYCLES.
- clk  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  asynchronous active-low reset (KEY[0] at top level).
- req  in  NREQ  level request per requester; bit i is requester i.
- data  in  16*NREQ  display value per requester; slice [16i+15:16i] belongs to requester i.
- gnt  out  NREQ  one-hot grant; all zero when the display is idle.
- hex_value  out  16  currently displayed value (registered).
- blank  out  1  high when no owner and all digits are dark.
- HEX0..HEX3  out  7 each, [0:6]  active-low segments for nibbles [3:0], [7:4], [11:8] and [15:12].

## Operation
- There are two states: IDLE and OWN. The block holds an owner index, a last-grant pointer `last`, and a dwell counter `cnt`.
- Reset values:
  - state IDLE, gnt 0, hex_value 16'h0000, blank 1, cnt 0.
  - `last` is NREQ-1, so requester 0 wins first.
  - All HEX outputs are 7'b1111111 (dark).
- Arbitration is round-robin. Search order is last+1, last+2, … modulo NREQ, and the first requester with req high wins.
- IDLE:
  - If any req is high, the winner becomes owner. At that edge: gnt = onehot(winner), last = winner, cnt = 0, blank = 0, hex_value = data[winner], state = OWN.
  - Otherwise the block stays in IDLE and remains dark.
- OWN, each cycle:
  - While req[owner] is high, hex_value reloads from data[owner], giving live tracking.
  - cnt increments and saturates at DWELL_CYCLES-1. Reaching that value sets the dwell as expired.
  - Owner release: if req[owner] goes low, re-arbitrate among the other requesters.
    - If another requester wins, hand over at the next edge; cnt resets to 0.
    - If none is pending, go to IDLE: gnt 0, blank 1, hex_value held.
  - Preemption: if the dwell has expired and any other requester is high, hand over to the round-robin winner with the owner excluded. cnt resets to 0.
  - If the dwell has expired and no other requester is pending, the owner keeps the display and cnt stays saturated.
- Simultaneous events:
  - Owner release and dwell expiry on the same cycle are treated as a release.
  - Multiple new requests resolve by round-robin order only.
- A requester that drops req before it is granted is simply skipped. There is no pending memory.
- Segment decoding: each nibble goes through hex7seg. When blank is 1, the decoder output is forced to 7'b1111111.

## Timing
- req rising in IDLE at edge t is sampled at edge t. gnt and hex_value update at that same edge and are visible in cycle t+1. Latency is 1 cycle.
- HEX outputs are combinational from hex_value and blank, so they carry no extra latency.
- Handover is a single edge. There is no idle gap cycle, and the old and new grant never overlap.
- Minimum ownership is DWELL_CYCLES cycles under contention, unless the owner releases earlier.
- resetn is asynchronous. Asserting it mid-operation forces all reset values immediately, independent of clk.

## Structure
- Shared package holds:
  - the state encoding (IDLE=1'b0, OWN=1'b1)
  - the blank segment constant 7'h7F
  - the nibble-to-digit mapping constants
- The round-robin winner search is one sub-module, rr_pick. Inputs: req, last, exclude_en, exclude_idx. Outputs: valid, idx. It is purely combinational.
- The existing hex7seg is instantiated four times and is not modified.

## Test plan
- Reset, then req=2'b01 with data0=16'h1234 → gnt=01 one cycle later; hex_value=16'h1234; HEX0 shows 4 and HEX3 shows 1; blank=0.
- With DWELL_CYCLES=8, owner 0 holding and req1 raised at cycle 2 → gnt switches to 10 exactly 8 cycles after grant 0; hex_value follows data1.
- Owner 1 drops req with none pending → next edge gnt=00, blank=1, all HEX=7'h7F, hex_value held.
- Both requesters raise req in the same cycle after reset → requester 0 wins. After its release, requester 1 wins with no gap cycle.
- Dwell expires with no contender → the owner is retained, cnt saturates, and a later req1 causes handover at the next edge.
- resetn pulsed low mid-OWN between clock edges → gnt=0, blank=1 and HEX dark immediately. After release, arbitration restarts with requester 0 first.
